// File: rtl/stg_dump_reader.sv
// Sequential storage dump reader: walks an inclusive, wrapping address range,
// fetches each word over a req/ack port, streams it out over valid/ready and
// keeps a 36-bit end-around-carry checksum of everything fetched.
module stg_dump_reader #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 36
) (
  input  logic              CL,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic [ADDR_W-1:0] FIRST_ADDR,
  input  logic [ADDR_W-1:0] LAST_ADDR,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [DATA_W-1:0] MEM_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_WORD,
  output logic [ADDR_W-1:0] OUT_ADDR,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] CHECKSUM
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_word_q, out_word_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W:0]   raw_sum;
  logic [DATA_W-1:0] eac_sum;

  // State and datapath registers; reset clears everything asynchronously
  always_ff @(posedge CL or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_q     <= '0;
      out_addr_q <= '0;
      out_word_q <= '0;
      checksum_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      out_addr_q <= out_addr_d;
      out_word_q <= out_word_d;
      checksum_q <= checksum_d;
    end
  end

  // Next-state logic; ABORT outranks MEM_ACK and OUT_READY
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) state_d = S_READ;
      end
      S_READ: begin
        if (ABORT)        state_d = S_FINISH;
        else if (MEM_ACK) state_d = S_PRESENT;
      end
      S_PRESENT: begin
        if (ABORT)          state_d = S_FINISH;
        else if (OUT_READY) state_d = (addr_q == last_q) ? S_FINISH : S_READ;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ones'-complement add: the carry out of the top bit wraps back into bit 0.
  // With both operands below 2^DATA_W the re-add can never carry again.
  always_comb begin
    raw_sum = {1'b0, checksum_q} + {1'b0, MEM_DATA};
    eac_sum = raw_sum[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, raw_sum[DATA_W]};
  end

  // Datapath updates: capture range on START, latch word and sum on ACK,
  // advance the wrapping address counter on acceptance
  always_comb begin
    addr_d     = addr_q;
    last_d     = last_q;
    out_addr_d = out_addr_q;
    out_word_d = out_word_q;
    checksum_d = checksum_q;
    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          addr_d     = FIRST_ADDR;
          last_d     = LAST_ADDR;
          checksum_d = '0;
        end
      end
      S_READ: begin
        if (!ABORT && MEM_ACK) begin
          out_word_d = MEM_DATA;
          out_addr_d = addr_q;
          checksum_d = eac_sum;
        end
      end
      S_PRESENT: begin
        if (!ABORT && OUT_READY && (addr_q != last_q)) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Moore outputs decoded from state
  always_comb begin
    MEM_REQ   = (state_q == S_READ);
    MEM_ADDR  = addr_q;
    OUT_VALID = (state_q == S_PRESENT);
    OUT_WORD  = out_word_q;
    OUT_ADDR  = out_addr_q;
    BUSY      = (state_q != S_IDLE);
    DONE      = (state_q == S_FINISH);
    CHECKSUM  = checksum_q;
  end

endmodule

// File: tb/tb_stg_dump_reader.sv
// Directed testbench for stg_dump_reader with a behavioural storage responder.
module tb_stg_dump_reader;

  logic        CL;
  logic        RESET;
  logic        START;
  logic        ABORT;
  logic [14:0] FIRST_ADDR;
  logic [14:0] LAST_ADDR;
  logic        MEM_REQ;
  logic [14:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [35:0] MEM_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [35:0] OUT_WORD;
  logic [14:0] OUT_ADDR;
  logic        BUSY;
  logic        DONE;
  logic [35:0] CHECKSUM;

  stg_dump_reader #(.ADDR_W(15), .DATA_W(36)) dut (
    .CL(CL), .RESET(RESET), .START(START), .ABORT(ABORT),
    .FIRST_ADDR(FIRST_ADDR), .LAST_ADDR(LAST_ADDR),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_WORD(OUT_WORD), .OUT_ADDR(OUT_ADDR),
    .BUSY(BUSY), .DONE(DONE), .CHECKSUM(CHECKSUM)
  );

  initial CL = 1'b0;
  always #5 CL = ~CL;

  logic [35:0] mem [0:32767];

  int          total = 0;
  int          bad   = 0;

  // responder configuration
  int unsigned ack_delay = 1;
  logic        abort_en = 1'b0;
  logic [14:0] abort_addr = '0;
  int unsigned req_cnt;

  // run_dump configuration and results
  int          stall_idx = -1;
  int unsigned stall_len = 0;
  logic        mid_start = 1'b0;
  int          n_words;
  int          n_done;
  logic        timed_out;
  logic        mreq_at_done;
  logic        busy_after;
  int unsigned stall_cnt;
  int unsigned stall_changes;
  int unsigned stall_req;
  logic [35:0] words [0:15];
  logic [14:0] addrs [0:15];

  // Storage model: acks ack_delay cycles into a request, optionally with ABORT
  initial begin
    MEM_ACK  = 1'b0;
    MEM_DATA = '0;
    ABORT    = 1'b0;
    req_cnt  = 0;
    forever begin
      @(negedge CL);
      if (MEM_REQ) req_cnt++;
      else         req_cnt = 0;
      if (MEM_REQ && req_cnt == ack_delay) begin
        MEM_ACK  = 1'b1;
        MEM_DATA = mem[MEM_ADDR];
        ABORT    = abort_en && (MEM_ADDR == abort_addr);
      end else begin
        MEM_ACK  = 1'b0;
        MEM_DATA = '0;
        ABORT    = 1'b0;
      end
    end
  end

  task automatic run_dump(input logic [14:0] f, input logic [14:0] l, input int unsigned budget);
    logic [35:0] hold_w;
    logic [14:0] hold_a;
    int unsigned cyc;
    n_words = 0; n_done = 0; timed_out = 1'b0; mreq_at_done = 1'b0; busy_after = 1'b0;
    stall_cnt = 0; stall_changes = 0; stall_req = 0;
    hold_w = '0; hold_a = '0;
    @(negedge CL);
    FIRST_ADDR = f; LAST_ADDR = l; START = 1'b1; OUT_READY = 1'b1;
    @(negedge CL);
    START = 1'b0;
    cyc = 0;
    while (!DONE && cyc < budget) begin
      if (OUT_VALID && n_words == stall_idx && stall_cnt < stall_len) begin
        if (stall_cnt == 0) begin
          hold_w = OUT_WORD; hold_a = OUT_ADDR;
        end else if (OUT_WORD !== hold_w || OUT_ADDR !== hold_a) begin
          stall_changes++;
        end
        if (MEM_REQ) stall_req++;
        stall_cnt++;
        OUT_READY = 1'b0;
      end else begin
        OUT_READY = 1'b1;
      end
      if (OUT_VALID && OUT_READY) begin
        if (n_words < 16) begin
          words[n_words] = OUT_WORD;
          addrs[n_words] = OUT_ADDR;
        end
        n_words++;
      end
      if (mid_start && cyc == 3) begin
        START = 1'b1; FIRST_ADDR = 15'o7; LAST_ADDR = 15'o7;
      end else begin
        START = 1'b0;
      end
      @(negedge CL);
      cyc++;
    end
    START = 1'b0;
    if (DONE) begin
      n_done = 1;
      mreq_at_done = MEM_REQ;
      @(negedge CL);
      if (DONE) n_done++;
      busy_after = BUSY;
    end else begin
      timed_out = 1'b1;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({MEM_REQ, OUT_VALID, BUSY, DONE} !== 4'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0000", {MEM_REQ, OUT_VALID, BUSY, DONE});
    end
    total++;
    if ({OUT_WORD, OUT_ADDR, CHECKSUM, MEM_ADDR} !== '0) begin
      bad++; $display("FAIL reset_data got word=%o addr=%o sum=%o maddr=%o want all 0",
                      OUT_WORD, OUT_ADDR, CHECKSUM, MEM_ADDR);
    end
  endtask

  task automatic test_sort_dump;
    logic [35:0] exp_w [0:10];
    exp_w = '{36'd8, 36'd4, 36'd4921, 36'd34, 36'd2482, 36'd321, 36'd2334,
              36'd99, 36'd2211, 36'd123, 36'd193};
    for (int unsigned k = 0; k < 11; k++) mem[15'o16 + 15'(k)] = exp_w[k];
    ack_delay = 3;
    run_dump(15'o16, 15'o30, 300);
    total++;
    if (timed_out || n_words != 11) begin
      bad++; $display("FAIL sort_count got=%0d timeout=%0b want=11", n_words, timed_out);
    end
    for (int unsigned k = 0; k < 11; k++) begin
      total++;
      if (words[k] !== exp_w[k] || addrs[k] !== 15'o16 + 15'(k)) begin
        bad++; $display("FAIL sort_word%0d got=%o@%o want=%o@%o", k, words[k], addrs[k],
                        exp_w[k], 15'o16 + 15'(k));
      end
    end
    total++;
    if (CHECKSUM !== 36'o000000030672) begin
      bad++; $display("FAIL sort_checksum got=%o want=000000030672", CHECKSUM);
    end
    total++;
    if (n_done != 1 || busy_after !== 1'b0) begin
      bad++; $display("FAIL sort_done got dones=%0d busy=%b want 1 and 0", n_done, busy_after);
    end
  endtask

  task automatic test_end_around;
    mem[15'o100] = 36'o777777777777;
    mem[15'o101] = 36'o000000000002;
    ack_delay = 2;
    run_dump(15'o100, 15'o101, 100);
    total++;
    if (timed_out || n_words != 2) begin
      bad++; $display("FAIL eac_count got=%0d want=2", n_words);
    end
    total++;
    if (CHECKSUM !== 36'o000000000002) begin
      bad++; $display("FAIL eac_checksum got=%o want=000000000002", CHECKSUM);
    end
  endtask

  task automatic test_wrap;
    logic [14:0] exp_a [0:3];
    exp_a = '{15'o77776, 15'o77777, 15'o00000, 15'o00001};
    ack_delay = 1;
    run_dump(15'o77776, 15'o00001, 100);
    total++;
    if (timed_out || n_words != 4 || n_done != 1) begin
      bad++; $display("FAIL wrap_count got=%0d dones=%0d want=4 and 1", n_words, n_done);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      total++;
      if (addrs[k] !== exp_a[k] || words[k] !== mem[exp_a[k]]) begin
        bad++; $display("FAIL wrap_word%0d got=%o@%o want=%o@%o", k, words[k], addrs[k],
                        mem[exp_a[k]], exp_a[k]);
      end
    end
  endtask

  task automatic test_stall;
    ack_delay = 2;
    stall_idx = 1; stall_len = 5;
    run_dump(15'o300, 15'o303, 200);
    stall_idx = -1; stall_len = 0;
    total++;
    if (stall_cnt != 5 || stall_changes != 0) begin
      bad++; $display("FAIL stall_hold got cycles=%0d changes=%0d want 5 and 0", stall_cnt, stall_changes);
    end
    total++;
    if (stall_req != 0) begin
      bad++; $display("FAIL stall_memreq got=%0d want=0", stall_req);
    end
    total++;
    if (timed_out || n_words != 4) begin
      bad++; $display("FAIL stall_count got=%0d want=4", n_words);
    end
    for (int unsigned k = 0; k < 4; k++) begin
      total++;
      if (addrs[k] !== 15'o300 + 15'(k) || words[k] !== mem[15'o300 + 15'(k)]) begin
        bad++; $display("FAIL stall_word%0d got=%o@%o want=%o@%o", k, words[k], addrs[k],
                        mem[15'o300 + 15'(k)], 15'o300 + 15'(k));
      end
    end
  endtask

  task automatic test_abort;
    mem[15'o200] = 36'o700000000000;
    mem[15'o201] = 36'o100000000005;
    mem[15'o202] = 36'o000000000123;
    ack_delay = 2;
    abort_en = 1'b1; abort_addr = 15'o202; mid_start = 1'b1;
    run_dump(15'o200, 15'o211, 200);
    abort_en = 1'b0; mid_start = 1'b0;
    total++;
    if (timed_out || n_words != 2 || n_done != 1) begin
      bad++; $display("FAIL abort_count got words=%0d dones=%0d want 2 and 1", n_words, n_done);
    end
    total++;
    if (addrs[0] !== 15'o200 || addrs[1] !== 15'o201) begin
      bad++; $display("FAIL abort_addrs got=%o,%o want=200,201", addrs[0], addrs[1]);
    end
    total++;
    if (CHECKSUM !== 36'o000000000006) begin
      bad++; $display("FAIL abort_checksum got=%o want=000000000006", CHECKSUM);
    end
    total++;
    if (mreq_at_done !== 1'b0 || busy_after !== 1'b0) begin
      bad++; $display("FAIL abort_idle got req=%b busy=%b want 0 0", mreq_at_done, busy_after);
    end
  endtask

  task automatic test_reset_mid;
    int unsigned cyc;
    int unsigned dones;
    ack_delay = 2;
    @(negedge CL);
    FIRST_ADDR = 15'o400; LAST_ADDR = 15'o405; START = 1'b1; OUT_READY = 1'b0;
    @(negedge CL);
    START = 1'b0;
    cyc = 0;
    while (!OUT_VALID && cyc < 20) begin
      @(negedge CL);
      cyc++;
    end
    total++;
    if (OUT_VALID !== 1'b1 || CHECKSUM !== mem[15'o400]) begin
      bad++; $display("FAIL rmid_present got valid=%b sum=%o want 1 and %o", OUT_VALID, CHECKSUM, mem[15'o400]);
    end
    RESET = 1'b1;
    #1;
    total++;
    if ({MEM_REQ, OUT_VALID, BUSY, DONE} !== 4'b0 || {OUT_WORD, OUT_ADDR, CHECKSUM, MEM_ADDR} !== '0) begin
      bad++; $display("FAIL rmid_async got ctrl=%b word=%o addr=%o sum=%o want all 0",
                      {MEM_REQ, OUT_VALID, BUSY, DONE}, OUT_WORD, OUT_ADDR, CHECKSUM);
    end
    dones = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge CL);
      if (DONE) dones++;
      if (k == 2) RESET = 1'b0;
    end
    OUT_READY = 1'b1;
    total++;
    if (dones != 0 || BUSY !== 1'b0) begin
      bad++; $display("FAIL rmid_nodone got dones=%0d busy=%b want 0 and 0", dones, BUSY);
    end
    run_dump(15'o5, 15'o5, 100);
    total++;
    if (timed_out || n_words != 1 || n_done != 1) begin
      bad++; $display("FAIL rmid_single got words=%0d dones=%0d want 1 and 1", n_words, n_done);
    end
    total++;
    if (addrs[0] !== 15'o5 || words[0] !== mem[15'o5] || CHECKSUM !== mem[15'o5]) begin
      bad++; $display("FAIL rmid_word got=%o@%o sum=%o want=%o@5", words[0], addrs[0], CHECKSUM, mem[15'o5]);
    end
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; OUT_READY = 1'b0;
    FIRST_ADDR = '0; LAST_ADDR = '0;
    for (int unsigned i = 0; i < 32768; i++) begin
      mem[i] = {6'o52, 15'(i), 15'(i ^ 32'h5A5A)};
    end
    repeat (2) @(negedge CL);
    test_reset;
    RESET = 1'b0;
    @(negedge CL);
    test_reset;
    test_sort_dump;
    test_end_around;
    test_wrap;
    test_stall;
    test_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
